edib_multi_clkgen: RTL and testbench
====================================

EDIB_MULTI_CLKGEN -- requirements
Module: edib_multi_clkgen

Interface
REQ-001 The block SHALL have parameter NCH, default 3, number of independent receive-clock channels (M2/M5/M7).
REQ-002 The block SHALL have parameter CW, default 5, width of each channel's half-period counter and divide field.
REQ-003 The block SHALL have parameter DEF_HALF, default 5, reset value of every channel's active half-period setting.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clk_12m  input  1  12 MHz system clock; all logic rising-edge.
REQ-006 The block SHALL have port en  input  NCH  per-channel enable, level.
REQ-007 The block SHALL have port half_div  input  NCH*CW  packed per-channel half-period setting; channel i at bits [i*CW+CW-1 : i*CW].
REQ-008 The block SHALL have port sync  input  1  synchronous one-cycle phase-realign request, common to all channels.
REQ-009 The block SHALL have port clk_out  output  NCH  generated divided clocks, registered.
REQ-010 The block SHALL have port rise_stb  output  NCH  one-cycle pulse, high in the same cycle clk_out[i] first reads 1.
REQ-011 The block SHALL have port fall_stb  output  NCH  one-cycle pulse, high in the same cycle clk_out[i] first reads 0 after a high phase, except after sync-forced falls.
REQ-012 The block SHALL have port active  output  NCH  1 when channel state is not OFF.

Function
REQ-013 Each channel SHALL run an independent FSM: OFF, LOW, HIGH; a CW-bit counter cnt; a CW-bit latched setting act_div.
REQ-014 The half-phase length SHALL be act_div+1 clk_12m cycles; full period 2*(act_div+1); act_div=0 gives divide-by-2; no overflow, since cnt never exceeds act_div.
REQ-015 In OFF, when en[i]=1, the channel SHALL go to LOW with cnt=0, act_div=half_div[i], clk_out=0.
REQ-016 In LOW, when cnt==act_div, the channel SHALL go to HIGH with cnt=0, clk_out=1, rise_stb=1; otherwise cnt increments.
REQ-017 In LOW, when en[i]=0, the channel SHALL go to OFF at the next edge with cnt=0; no strobe.
REQ-018 In HIGH, the high phase SHALL always complete regardless of en[i]; no runt pulses.
REQ-019 In HIGH, when cnt==act_div, the channel SHALL set clk_out=0, fall_stb=1, cnt=0, then go to LOW reloading act_div=half_div[i] if en[i]=1, else go to OFF.
REQ-020 half_div changes SHALL take effect only at OFF->LOW, at the end of a high phase, or on sync; mid-period changes SHALL NOT alter the current period.
REQ-021 When sync=1, every channel not in OFF SHALL go to LOW with cnt=0, clk_out=0, act_div=half_div[i], and no rise_stb or fall_stb; OFF channels SHALL be unaffected unless en[i]=1, in which case REQ-015 applies.
REQ-022 Priority SHALL be reset > sync > en/terminal count.
REQ-023 rise_stb and fall_stb SHALL be registered, never both high, and each high for exactly one cycle per event.

Reset
REQ-024 While reset=0, all channels SHALL be OFF with cnt=0, act_div=DEF_HALF, clk_out=0, rise_stb=0, fall_stb=0, active=0.
REQ-025 Reset assertion mid-period SHALL force the reset values immediately, with no partial pulse completion.
REQ-026 After reset release, a channel with en[i]=1 SHALL enter LOW on the first clk_12m edge.

Verification
REQ-027 The bench SHALL cover: defaults with en=3'b111, half_div all 5 -> each clk_out 1 MHz, first rise_stb on 7th edge after release, period 12 cycles, duty 50%.
REQ-028 The bench SHALL cover: ch0 half_div=0, ch1=2, ch2=31 -> periods 2, 6, 64 cycles; one rise_stb and one fall_stb per period.
REQ-029 The bench SHALL cover: half_div change 5->2 at mid high phase -> current high lasts 6 cycles, following periods 6 cycles, no glitch.
REQ-030 The bench SHALL cover: en[1] dropped 2 cycles into high phase -> high lasts full 6 cycles, fall_stb pulses, then OFF with active[1]=0; en dropped in LOW -> OFF next edge, no strobe.
REQ-031 The bench SHALL cover: sync pulse while channels are at mixed phases -> all active clk_out=0 next cycle, no strobes, then identical-setting channels produce coincident rises act_div+1 cycles later.
REQ-032 The bench SHALL cover: reset asserted during HIGH -> clk_out=0 asynchronously, all outputs 0; release -> restart per REQ-026.

Source files
------------

// File: rtl/edib_multi_clkgen.sv
// edib_multi_clkgen
// Generates NCH independent divided receive clocks from the 12 MHz system
// clock. Each channel spends act_div+1 cycles low and act_div+1 cycles high.
// Registered rise/fall strobes mark the edges. A common sync input realigns
// every running channel to the start of a low phase.
module edib_multi_clkgen #(
    parameter int NCH      = 3,
    parameter int CW       = 5,
    parameter int DEF_HALF = 5
) (
    input  logic              reset,
    input  logic              clk_12m,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*CW-1:0] half_div,
    input  logic              sync,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    rise_stb,
    output logic [NCH-1:0]    fall_stb,
    output logic [NCH-1:0]    active
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            state_t          state_q, state_d;
            logic [CW-1:0]   cnt_q, cnt_d;
            logic [CW-1:0]   act_q, act_d;
            logic            clk_q, clk_d;
            logic            rise_q, rise_d;
            logic            fall_q, fall_d;
            logic [CW-1:0]   half_sel;
            logic            term;
            logic            realign;

            assign half_sel = half_div[gi*CW +: CW];
            // Terminal count of the current half phase; cnt never passes act_q.
            assign term     = (cnt_q == act_q);
            // Sync only touches channels that are already running.
            assign realign  = sync && (state_q != ST_OFF);

            // State and datapath registers; reset clears everything at once,
            // so no partially completed pulse survives a mid-period reset.
            always_ff @(posedge clk_12m or negedge reset) begin
                if (!reset) begin
                    state_q <= ST_OFF;
                    cnt_q   <= '0;
                    act_q   <= CW'(DEF_HALF);
                    clk_q   <= 1'b0;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    act_q   <= act_d;
                    clk_q   <= clk_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            // Next-state: sync beats enable/terminal count; a high phase
            // always runs to completion even if en drops.
            always_comb begin
                state_d = state_q;
                if (realign) begin
                    state_d = ST_LOW;
                end else begin
                    case (state_q)
                        ST_OFF: begin
                            if (en[gi]) state_d = ST_LOW;
                        end
                        ST_LOW: begin
                            if (!en[gi])   state_d = ST_OFF;
                            else if (term) state_d = ST_HIGH;
                        end
                        ST_HIGH: begin
                            if (term) state_d = en[gi] ? ST_LOW : ST_OFF;
                        end
                        default: state_d = ST_OFF;
                    endcase
                end
            end

            // Counter, latched setting, clock level and strobes. The setting
            // is only reloaded at start-up, end of a high phase or on sync,
            // so a mid-period half_div change never bends the current period.
            always_comb begin
                cnt_d  = cnt_q;
                act_d  = act_q;
                clk_d  = clk_q;
                rise_d = 1'b0;
                fall_d = 1'b0;
                if (realign) begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    act_d = half_sel;
                end else begin
                    case (state_q)
                        ST_OFF: begin
                            cnt_d = '0;
                            clk_d = 1'b0;
                            if (en[gi]) act_d = half_sel;
                        end
                        ST_LOW: begin
                            if (!en[gi]) begin
                                cnt_d = '0;
                                clk_d = 1'b0;
                            end else if (term) begin
                                cnt_d  = '0;
                                clk_d  = 1'b1;
                                rise_d = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        ST_HIGH: begin
                            if (term) begin
                                cnt_d  = '0;
                                clk_d  = 1'b0;
                                fall_d = 1'b1;
                                if (en[gi]) act_d = half_sel;
                            end else begin
                                cnt_d = cnt_q + CW'(1);
                            end
                        end
                        default: begin
                            cnt_d = '0;
                            clk_d = 1'b0;
                        end
                    endcase
                end
            end

            assign clk_out[gi]  = clk_q;
            assign rise_stb[gi] = rise_q;
            assign fall_stb[gi] = fall_q;
            assign active[gi]   = (state_q != ST_OFF);
        end
    endgenerate

endmodule

// File: tb/tb_edib_multi_clkgen.sv
// Testbench for edib_multi_clkgen: expected strobe events (kind and cycle)
// are queued per channel by the stimulus; a monitor pops and compares each
// strobe the DUT produces. Level checks cover reset, active and clk_out.
module tb_edib_multi_clkgen;

    localparam int NCH = 3;
    localparam int CW  = 5;

    logic              reset;
    logic              clk_12m = 1'b0;
    logic [NCH-1:0]    en;
    logic [NCH*CW-1:0] half_div;
    logic              sync;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    rise_stb;
    logic [NCH-1:0]    fall_stb;
    logic [NCH-1:0]    active;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct packed {
        logic is_fall;
        int   at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    edib_multi_clkgen #(.NCH(NCH), .CW(CW), .DEF_HALF(5)) dut (
        .reset    (reset),
        .clk_12m  (clk_12m),
        .en       (en),
        .half_div (half_div),
        .sync     (sync),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .active   (active)
    );

    always #5 clk_12m = ~clk_12m;

    // Edge counter: value N at a negedge means N rising edges have occurred.
    always @(posedge clk_12m) cyc <= cyc + 1;

    task automatic push_exp(input int ch, input logic f, input int at);
        exp_t e;
        e.is_fall = f;
        e.at      = at;
        case (ch)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Queue a steady train: rises every 2*(h+1) cycles from first_rise,
    // each fall h+1 cycles after its rise, up to and including edge last.
    task automatic push_train(input int ch, input int h, input int first_rise, input int last);
        for (int r = first_rise; r <= last; r += 2 * (h + 1)) begin
            push_exp(ch, 1'b0, r);
            if (r + h + 1 <= last) push_exp(ch, 1'b1, r + h + 1);
        end
    endtask

    function automatic int qsize(input int ch);
        case (ch)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_exp(input int ch);
        case (ch)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_event(input int ch, input logic f);
        exp_t e;
        vectors++;
        if (qsize(ch) == 0) begin
            miscompares++;
            $display("FAIL unexpected_%s ch%0d: strobe at cycle %0d, none expected",
                     f ? "fall" : "rise", ch, cyc);
        end else begin
            e = pop_exp(ch);
            if (e.is_fall !== f || e.at != cyc) begin
                miscompares++;
                $display("FAIL strobe ch%0d: got %s at cycle %0d expected %s at cycle %0d",
                         ch, f ? "fall" : "rise", cyc, e.is_fall ? "fall" : "rise", e.at);
            end
        end
    endtask

    // Monitor: every strobe the DUT shows is matched against the queue.
    always @(negedge clk_12m) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (rise_stb[ch] && fall_stb[ch]) begin
                vectors++;
                miscompares++;
                $display("FAIL both_strobes ch%0d: rise and fall high together at cycle %0d", ch, cyc);
            end else if (rise_stb[ch] || fall_stb[ch]) begin
                check_event(ch, fall_stb[ch]);
            end
        end
    end

    // Return just after the negedge that follows edge t.
    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_12m);
        #1;
    endtask

    task automatic drain(input string name);
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("%s_missing_ch%0d", name, ch), qsize(ch), 0);
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic apply_reset(input string name);
        reset = 1'b0;
        #1;
        chk({name, "_rst_clk"},    {29'd0, clk_out},  32'd0);
        chk({name, "_rst_rise"},   {29'd0, rise_stb}, 32'd0);
        chk({name, "_rst_fall"},   {29'd0, fall_stb}, 32'd0);
        chk({name, "_rst_active"}, {29'd0, active},   32'd0);
        @(negedge clk_12m);
        @(negedge clk_12m);
        #1;
    endtask

    task automatic release_rst(output int b);
        reset = 1'b1;
        b     = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int b2;
        reset    = 1'b0;
        en       = '0;
        sync     = 1'b0;
        half_div = {5'd5, 5'd5, 5'd5};
        @(negedge clk_12m);
        #1;
        chk("init_clk",    {29'd0, clk_out}, 32'd0);
        chk("init_active", {29'd0, active},  32'd0);
        wait_to(3);

        // Defaults: 12-cycle period, first rise on 7th edge after release.
        en = 3'b111;
        release_rst(b);
        for (int ch = 0; ch < NCH; ch++) push_train(ch, 5, b + 7, b + 32);
        $display("T1 defaults: release at cycle %0d", b);
        wait_to(b + 1);
        chk("t1_active_first_edge", {29'd0, active},  32'd7);
        chk("t1_clk_low_first",     {29'd0, clk_out}, 32'd0);
        wait_to(b + 6);
        chk("t1_clk_before_rise",   {29'd0, clk_out}, 32'd0);
        wait_to(b + 7);
        chk("t1_clk_high",          {29'd0, clk_out}, 32'd7);
        wait_to(b + 13);
        chk("t1_clk_low_again",     {29'd0, clk_out}, 32'd0);
        wait_to(b + 32);
        drain("t1");
        apply_reset("t1");

        // Mixed settings: 0, 2, 31 -> periods 2, 6, 64.
        half_div = {5'd31, 5'd2, 5'd0};
        en       = 3'b111;
        release_rst(b);
        push_train(0, 0,  b + 2,  b + 130);
        push_train(1, 2,  b + 4,  b + 130);
        push_train(2, 31, b + 33, b + 130);
        $display("T2 mixed dividers: release at cycle %0d", b);
        wait_to(b + 33);
        chk("t2_ch2_high", {31'd0, clk_out[2]}, 32'd1);
        wait_to(b + 130);
        drain("t2");
        apply_reset("t2");

        // Setting change in mid high phase: current high still 6 cycles.
        half_div = {5'd5, 5'd5, 5'd5};
        en       = 3'b001;
        release_rst(b);
        push_exp(0, 1'b0, b + 7);
        push_exp(0, 1'b1, b + 13);
        push_train(0, 2, b + 16, b + 40);
        $display("T3 mid-high change 5->2: release at cycle %0d", b);
        wait_to(b + 9);
        half_div[4:0] = 5'd2;
        wait_to(b + 12);
        chk("t3_still_high", {31'd0, clk_out[0]}, 32'd1);
        wait_to(b + 13);
        chk("t3_fell",       {31'd0, clk_out[0]}, 32'd0);
        wait_to(b + 40);
        drain("t3");
        apply_reset("t3");

        // Enable dropped during high (ch1) and during low (ch0).
        half_div = {5'd5, 5'd5, 5'd5};
        en       = 3'b011;
        release_rst(b);
        push_exp(0, 1'b0, b + 7);
        push_exp(0, 1'b1, b + 13);
        push_exp(1, 1'b0, b + 7);
        push_exp(1, 1'b1, b + 13);
        $display("T4 enable drop: release at cycle %0d", b);
        wait_to(b + 9);
        en[1] = 1'b0;
        wait_to(b + 12);
        chk("t4_ch1_high_full",   {31'd0, clk_out[1]}, 32'd1);
        chk("t4_ch1_active_high", {31'd0, active[1]},  32'd1);
        wait_to(b + 13);
        chk("t4_ch1_off",         {31'd0, active[1]},  32'd0);
        chk("t4_ch1_clk_low",     {31'd0, clk_out[1]}, 32'd0);
        wait_to(b + 15);
        chk("t4_ch0_active_low",  {31'd0, active[0]},  32'd1);
        en[0] = 1'b0;
        wait_to(b + 16);
        chk("t4_all_off",         {29'd0, active},     32'd0);
        wait_to(b + 30);
        drain("t4");
        apply_reset("t4");

        // Sync with channels at mixed phases.
        half_div = {5'd2, 5'd5, 5'd5};
        en       = 3'b101;
        release_rst(b);
        push_exp(0, 1'b0, b + 7);
        push_exp(0, 1'b1, b + 13);
        push_exp(1, 1'b0, b + 10);
        push_exp(2, 1'b0, b + 4);
        push_exp(2, 1'b1, b + 7);
        push_exp(2, 1'b0, b + 10);
        push_exp(2, 1'b1, b + 13);
        $display("T5 sync realign: release at cycle %0d", b);
        wait_to(b + 3);
        en = 3'b111;
        wait_to(b + 14);
        chk("t5_phase_before_sync", {29'd0, clk_out}, 32'd2);
        sync = 1'b1;
        wait_to(b + 15);
        sync = 1'b0;
        chk("t5_clk_after_sync",    {29'd0, clk_out}, 32'd0);
        chk("t5_active_after_sync", {29'd0, active},  32'd7);
        push_train(0, 5, b + 21, b + 40);
        push_train(1, 5, b + 21, b + 40);
        push_train(2, 2, b + 18, b + 40);
        wait_to(b + 21);
        chk("t5_coincident_rise",   {30'd0, clk_out[1:0]}, 32'd3);
        wait_to(b + 40);
        drain("t5");
        apply_reset("t5");

        // Asynchronous reset in the middle of a high phase.
        half_div = {5'd5, 5'd5, 5'd5};
        en       = 3'b111;
        release_rst(b);
        for (int ch = 0; ch < NCH; ch++) push_exp(ch, 1'b0, b + 7);
        $display("T6 reset during high: release at cycle %0d", b);
        wait_to(b + 9);
        chk("t6_high_before_rst", {29'd0, clk_out}, 32'd7);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_clk",    {29'd0, clk_out},  32'd0);
        chk("t6_async_rise",   {29'd0, rise_stb}, 32'd0);
        chk("t6_async_fall",   {29'd0, fall_stb}, 32'd0);
        chk("t6_async_active", {29'd0, active},   32'd0);
        wait_to(b + 14);
        drain("t6a");
        release_rst(b2);
        for (int ch = 0; ch < NCH; ch++) push_train(ch, 5, b2 + 7, b2 + 20);
        wait_to(b2 + 1);
        chk("t6_restart_active", {29'd0, active},  32'd7);
        chk("t6_restart_clk",    {29'd0, clk_out}, 32'd0);
        wait_to(b2 + 20);
        drain("t6b");
        apply_reset("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
